tile_reset_ctrl_multi: RTL and testbench
========================================

// Module: tile_reset_ctrl_multi
// PURPOSE
//  TL-UL register slave giving software per-tile reset control for N_TILES tiles. Each tile has a level-held
//  reset bit and a write-1 self-timed reset pulse of programmable length. Sits on the cbus next to the
//  clock/reset crossing; tile_reset_o drives the per-tile reset sinks. Response is registered (1-entry D buffer).
// PARAMETERS
//  N_TILES     4      number of tiles (1..64); one bit per tile in every register
//  SRC_W       9      A/D source id width
//  ADDR_W      21     A address width; register index = a_address[11:3]
//  CNT_W       8      pulse-length counter width
//  RESET_INIT  '0     N_TILES-bit reset value of TILE_RESET (1 = tile held in reset out of reset)
//  DEF_PULSE   16     reset value of PULSE_LEN
// PORTS
//  clock         in   1        single clock
//  reset         in   1        asynchronous, active-low
//  a_valid       in   1        A request valid
//  a_ready       out  1        A request ready
//  a_opcode      in   3        4 = Get; 0/1 = Put Full/Partial; other values treated as Put
//  a_size        in   2        echoed on d_size
//  a_source      in   SRC_W    echoed on d_source
//  a_address     in   ADDR_W   byte address
//  a_mask        in   8        byte write mask
//  a_data        in   64       write data
//  d_valid       out  1        D response valid
//  d_ready       in   1        D response ready
//  d_opcode      out  3        1 = AccessAckData (Get), 0 = AccessAck (Put)
//  d_size        out  2        captured a_size
//  d_source      out  SRC_W    captured a_source
//  d_data        out  64       read data; 0 for Puts and unmapped indices
//  tile_reset_o  out  N_TILES  per-tile reset, 1 = asserted, driven directly from a flop
// BEHAVIOUR
//  Register map (index = a_address[11:3]); per-bit write enable wen[b] = a_mask[b/8]:
//   0 TILE_RESET  RW  level bits
//   1 PULSE       W1  writing 1 starts/restarts that tile's pulse; read = busy (cnt != 0)
//   2 PULSE_LEN   RW  CNT_W bits; written 0 is stored but loads as 1
//   3 STATUS      RO  current tile_reset_o; writes ignored
//   others        reads 0, writes ignored, normal ack
//  Reset (async assert): TILE_RESET = RESET_INIT, PULSE_LEN = DEF_PULSE, all cnt = 0, d_valid = 0,
//   tile_reset_o = RESET_INIT, d_* data fields 0.
//  Handshake: a_ready = !d_valid | d_ready. Accept = a_valid & a_ready at edge T; d_valid = 1 from T+1
//   until d_valid & d_ready. Back-to-back accepts allowed when d_ready stays high (1 req/cycle).
//  Read data sampled at accept from pre-write state; write takes effect at the accept edge.
//  Pulse: on accepted write to PULSE with bit i set, cnt[i] <= max(PULSE_LEN,1). Else cnt[i] decrements when nonzero.
//   A write to PULSE while busy reloads (restart). Saturating: never underflows.
//  tile_reset_o[i] <= next TILE_RESET[i] | (next cnt[i] != 0). A pulse of length L is high exactly L cycles,
//   starting the cycle after accept. Level and pulse are OR-ed and independent; clearing TILE_RESET does not cancel a pulse.
//  Mid-operation async reset: all state returns to reset values immediately; the in-flight response is dropped.
//  Bits at or above N_TILES read 0 and are not written.
// STRUCTURE
//  Package tile_reset_pkg: register index constants (REG_TILE_RESET..REG_STATUS), TL opcode constants
//   (GET=4, ACK=0, ACK_DATA=1).
//  Sub-module tile_reset_pulse_ctr (CNT_W): load/len inputs, busy output; instantiated N_TILES times.
//   The top holds the regfile, D buffer and output flops.
// TESTING
//  1 Reset with RESET_INIT=4'b0101 -> tile_reset_o=0101, Get idx3 returns 0x5, Get idx2 returns 16, d_valid low in reset.
//  2 Put idx2 data 4, then Put idx1 data 0x2 mask 0x01 -> tile_reset_o[1] high exactly 4 cycles from
//    accept+1; Get idx1 mid-pulse returns 0x2, after it returns 0.
//  3 Restart: pulse tile0 (len 4), rewrite PULSE bit0 at cycle 2 -> high 6 cycles total; PULSE_LEN=0 -> 1-cycle pulse.
//  4 Put idx0 data 0xF mask 0x00 -> no change; mask 0x01 -> tile_reset_o = 0xF; set TILE_RESET[2], then
//    clear it during a tile2 pulse -> stays high until the pulse ends.
//  5 d_ready=0 with 3 queued Gets -> a_ready low after the first accept; d fields held stable; releasing d_ready
//    drains one response per cycle with correct source ids.
//  6 Assert reset during a pulse with d_valid high -> tile_reset_o=RESET_INIT, d_valid=0 immediately; no stale response after release.

Source files
------------

// File: rtl/tile_reset_pkg.sv
// Shared register indices and TileLink opcodes for the per-tile reset controller.
package tile_reset_pkg;

   localparam logic [8:0] REG_TILE_RESET = 9'd0;
   localparam logic [8:0] REG_PULSE      = 9'd1;
   localparam logic [8:0] REG_PULSE_LEN  = 9'd2;
   localparam logic [8:0] REG_STATUS     = 9'd3;

   localparam logic [2:0] TL_GET      = 3'd4;
   localparam logic [2:0] TL_ACK      = 3'd0;
   localparam logic [2:0] TL_ACK_DATA = 3'd1;

endpackage

// File: rtl/tile_reset_pulse_ctr.sv
// Saturating down-counter for one tile's self-timed reset pulse; a load of 0 behaves as 1.
module tile_reset_pulse_ctr #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             busy_nxt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (len == '0) ? CNT_W'(1) : len;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy     = (cnt_q != '0);
   // Lets the top register tile_reset_o from the post-edge counter value.
   assign busy_nxt = (cnt_d != '0);

endmodule

// File: rtl/tile_reset_ctrl_multi.sv
// TL-UL register slave for per-tile reset: level bits, self-timed pulses, registered D response.
module tile_reset_ctrl_multi
   import tile_reset_pkg::*;
#(
   parameter int                 N_TILES    = 4,
   parameter int                 SRC_W      = 9,
   parameter int                 ADDR_W     = 21,
   parameter int                 CNT_W      = 8,
   parameter logic [N_TILES-1:0] RESET_INIT = '0,
   parameter int                 DEF_PULSE  = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [2:0]         a_opcode,
   input  logic [1:0]         a_size,
   input  logic [SRC_W-1:0]   a_source,
   input  logic [ADDR_W-1:0]  a_address,
   input  logic [7:0]         a_mask,
   input  logic [63:0]        a_data,
   output logic               d_valid,
   input  logic               d_ready,
   output logic [2:0]         d_opcode,
   output logic [1:0]         d_size,
   output logic [SRC_W-1:0]   d_source,
   output logic [63:0]        d_data,
   output logic [N_TILES-1:0] tile_reset_o
);

   logic [N_TILES-1:0] tile_reset_q, tile_reset_d;
   logic [CNT_W-1:0]   pulse_len_q, pulse_len_d;
   logic [N_TILES-1:0] tile_reset_o_q, tile_reset_o_d;
   logic               d_valid_q, d_valid_d;
   logic [2:0]         d_opcode_q, d_opcode_d;
   logic [1:0]         d_size_q, d_size_d;
   logic [SRC_W-1:0]   d_source_q, d_source_d;
   logic [63:0]        d_data_q, d_data_d;

   logic [N_TILES-1:0] pulse_load;
   logic [N_TILES-1:0] busy;
   logic [N_TILES-1:0] busy_nxt;
   logic [8:0]         reg_idx;
   logic               accept;
   logic               is_get;
   logic               wr_en;
   logic [63:0]        rdata;
   logic               unused_in;

   assign reg_idx   = a_address[11:3];
   assign a_ready   = !d_valid_q || d_ready;
   assign accept    = a_valid && a_ready;
   assign is_get    = (a_opcode == TL_GET);
   assign wr_en     = accept && !is_get;
   assign unused_in = ^{a_address, a_data, a_mask};

   for (genvar g = 0; g < N_TILES; g++) begin : g_pulse
      tile_reset_pulse_ctr #(.CNT_W(CNT_W)) u_ctr (
         .clock    (clock),
         .reset    (reset),
         .load     (pulse_load[g]),
         .len      (pulse_len_q),
         .busy     (busy[g]),
         .busy_nxt (busy_nxt[g])
      );
   end

   always_comb begin
      tile_reset_d = tile_reset_q;
      pulse_len_d  = pulse_len_q;
      pulse_load   = '0;
      for (int i = 0; i < N_TILES; i++) begin
         if (wr_en && a_mask[i/8]) begin
            if (reg_idx == REG_TILE_RESET) tile_reset_d[i] = a_data[i];
            if (reg_idx == REG_PULSE)      pulse_load[i]   = a_data[i];
         end
      end
      for (int b = 0; b < CNT_W; b++) begin
         if (wr_en && (reg_idx == REG_PULSE_LEN) && a_mask[b/8]) pulse_len_d[b] = a_data[b];
      end
      tile_reset_o_d = tile_reset_d | busy_nxt;
   end

   // Read value reflects state before any write accepted on the same edge.
   always_comb begin
      rdata = '0;
      case (reg_idx)
         REG_TILE_RESET: rdata[N_TILES-1:0] = tile_reset_q;
         REG_PULSE:      rdata[N_TILES-1:0] = busy;
         REG_PULSE_LEN:  rdata[CNT_W-1:0]   = pulse_len_q;
         REG_STATUS:     rdata[N_TILES-1:0] = tile_reset_o_q;
         default:        rdata = '0;
      endcase
   end

   always_comb begin
      d_valid_d  = d_valid_q;
      d_opcode_d = d_opcode_q;
      d_size_d   = d_size_q;
      d_source_d = d_source_q;
      d_data_d   = d_data_q;
      if (accept) begin
         d_valid_d  = 1'b1;
         d_opcode_d = is_get ? TL_ACK_DATA : TL_ACK;
         d_size_d   = a_size;
         d_source_d = a_source;
         d_data_d   = is_get ? rdata : 64'd0;
      end else if (d_ready) begin
         d_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tile_reset_q   <= RESET_INIT;
         pulse_len_q    <= CNT_W'(DEF_PULSE);
         tile_reset_o_q <= RESET_INIT;
         d_valid_q      <= 1'b0;
         d_opcode_q     <= '0;
         d_size_q       <= '0;
         d_source_q     <= '0;
         d_data_q       <= '0;
      end else begin
         tile_reset_q   <= tile_reset_d;
         pulse_len_q    <= pulse_len_d;
         tile_reset_o_q <= tile_reset_o_d;
         d_valid_q      <= d_valid_d;
         d_opcode_q     <= d_opcode_d;
         d_size_q       <= d_size_d;
         d_source_q     <= d_source_d;
         d_data_q       <= d_data_d;
      end
   end

   assign tile_reset_o = tile_reset_o_q;
   assign d_valid      = d_valid_q;
   assign d_opcode     = d_opcode_q;
   assign d_size       = d_size_q;
   assign d_source     = d_source_q;
   assign d_data       = d_data_q;

endmodule

// File: tb/tb_tile_reset_ctrl_multi.sv
// Bench for tile_reset_ctrl_multi: directed scenarios plus random traffic against a cycle model.
module tb_tile_reset_ctrl_multi;

   localparam int             N      = 4;
   localparam int             SRC_W  = 9;
   localparam int             ADDR_W = 21;
   localparam int             CNT_W  = 8;
   localparam logic [N-1:0]   RINIT  = 4'b0101;
   localparam int             DEFP   = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              a_valid = 1'b0;
   logic              a_ready;
   logic [2:0]        a_opcode = '0;
   logic [1:0]        a_size = '0;
   logic [SRC_W-1:0]  a_source = '0;
   logic [ADDR_W-1:0] a_address = '0;
   logic [7:0]        a_mask = '0;
   logic [63:0]       a_data = '0;
   logic              d_valid;
   logic              d_ready = 1'b1;
   logic [2:0]        d_opcode;
   logic [1:0]        d_size;
   logic [SRC_W-1:0]  d_source;
   logic [63:0]       d_data;
   logic [N-1:0]      tile_reset_o;

   always #5 clock = ~clock;

   tile_reset_ctrl_multi #(
      .N_TILES(N), .SRC_W(SRC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
      .RESET_INIT(RINIT), .DEF_PULSE(DEFP)
   ) dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
      .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
      .d_source(d_source), .d_data(d_data), .tile_reset_o(tile_reset_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: plain integers per tile, no notion of the RTL's flops.
   logic [N-1:0]     m_tr, m_out;
   int               m_len;
   int               m_cnt [N];
   bit               m_dv;
   logic [2:0]       m_dop;
   logic [1:0]       m_dsize;
   logic [SRC_W-1:0] m_dsrc;
   logic [63:0]      m_ddata;

   logic [63:0]      last_rd;
   int               hi_cnt [N];
   int               n_rsp;
   bit               last_acc;
   logic [SRC_W-1:0] rsp_src [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_tr = RINIT; m_out = RINIT; m_len = DEFP; m_dv = 0;
      m_dop = '0; m_dsize = '0; m_dsrc = '0; m_ddata = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic model_update();
      logic [63:0] rd;
      int idx, len_old;
      bit acc, is_get;
      bit start [N];
      if (!reset) begin
         model_reset();
         return;
      end
      acc     = a_valid && (!m_dv || d_ready);
      idx     = int'(a_address[11:3]);
      is_get  = (a_opcode == 3'd4);
      len_old = m_len;
      for (int i = 0; i < N; i++) start[i] = 0;
      if (acc) begin
         rd = '0;
         if (is_get) begin
            case (idx)
               0: rd = 64'(m_tr);
               1: for (int i = 0; i < N; i++) rd[i] = (m_cnt[i] > 0);
               2: rd = 64'(m_len);
               3: rd = 64'(m_out);
               default: rd = '0;
            endcase
         end
         m_dv = 1; m_dop = is_get ? 3'd1 : 3'd0; m_dsize = a_size; m_dsrc = a_source; m_ddata = rd;
         if (!is_get) begin
            for (int i = 0; i < N; i++) begin
               if (idx == 0 && a_mask[i/8]) m_tr[i] = a_data[i];
               if (idx == 1 && a_mask[i/8] && a_data[i]) start[i] = 1;
            end
            if (idx == 2 && a_mask[0]) m_len = int'(a_data[7:0]);
         end
      end else if (m_dv && d_ready) begin
         m_dv = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (start[i]) m_cnt[i] = (len_old == 0) ? 1 : len_old;
         else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
         m_out[i] = m_tr[i] || (m_cnt[i] > 0);
      end
   endtask

   // One clock: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic step();
      @(negedge clock);
      chk("tile_reset_o", 64'(tile_reset_o), 64'(m_out));
      chk("d_valid", 64'(d_valid), 64'(m_dv));
      chk("a_ready", 64'(a_ready), 64'(!m_dv || d_ready));
      if (m_dv) begin
         chk("d_opcode", 64'(d_opcode), 64'(m_dop));
         chk("d_size", 64'(d_size), 64'(m_dsize));
         chk("d_source", 64'(d_source), 64'(m_dsrc));
         chk("d_data", d_data, m_ddata);
      end
      for (int i = 0; i < N; i++) if (tile_reset_o[i]) hi_cnt[i]++;
      if (d_valid && d_ready) begin
         last_rd = d_data;
         n_rsp++;
         rsp_src.push_back(d_source);
      end
      last_acc = a_valid && a_ready;
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic [2:0] op, input int idx, input logic [63:0] data,
                      input logic [7:0] mask);
      logic [ADDR_W-1:0] addr;
      addr       = ADDR_W'($urandom);
      addr[11:3] = 9'(idx);
      a_valid = 1; a_opcode = op; a_address = addr; a_data = data; a_mask = mask;
      a_size = 2'($urandom); a_source = SRC_W'($urandom);
      step();
      a_valid = 0;
   endtask

   task automatic put(input int idx, input logic [63:0] data, input logic [7:0] mask);
      req(3'd0, idx, data, mask);
   endtask

   task automatic get_rd(input int idx, output logic [63:0] rd);
      req(3'd4, idx, 64'(0), 8'hFF);
      step();
      rd = last_rd;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clr_hi();
      for (int i = 0; i < N; i++) hi_cnt[i] = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      int n0, budget;
      logic [SRC_W-1:0] srcs [3];
      int sent;
      model_reset();
      n_rsp = 0;
      clr_hi();

      // 1: reset values
      idle(3);
      reset = 1'b1;
      chk("rst_out", 64'(tile_reset_o), 64'(RINIT));
      get_rd(3, rd);
      chk("rst_status", rd, 64'h5);
      get_rd(2, rd);
      chk("rst_len", rd, 64'd16);

      // 2: 4-cycle pulse on tile1, busy readback
      put(2, 64'd4, 8'h01);
      clr_hi();
      put(1, 64'h2, 8'h01);
      get_rd(1, rd);
      chk("busy_mid", rd, 64'h2);
      idle(6);
      get_rd(1, rd);
      chk("busy_after", rd, 64'h0);
      chk("pulse4_len", 64'(hi_cnt[1]), 64'd4);

      // 3: restart extends pulse; zero length gives one cycle
      put(0, 64'h0, 8'h01);
      idle(2);
      clr_hi();
      put(1, 64'h1, 8'h01);
      step();
      put(1, 64'h1, 8'h01);
      idle(10);
      chk("restart_len", 64'(hi_cnt[0]), 64'd6);
      put(2, 64'h0, 8'h01);
      clr_hi();
      put(1, 64'h1, 8'h01);
      idle(4);
      chk("len0_pulse", 64'(hi_cnt[0]), 64'd1);

      // 4: masked level writes; clearing level mid-pulse keeps pulse
      put(0, 64'hF, 8'h00);
      step();
      chk("mask0_nochg", 64'(tile_reset_o), 64'h0);
      put(0, 64'hF, 8'h01);
      step();
      chk("mask1_set", 64'(tile_reset_o), 64'hF);
      put(0, 64'h4, 8'h01);
      put(2, 64'd8, 8'h01);
      put(1, 64'h4, 8'h01);
      clr_hi();
      step();
      put(0, 64'h0, 8'h01);
      idle(10);
      chk("lvl_clr_pulse", 64'(hi_cnt[2]), 64'd8);

      // 5: back-pressure with three queued Gets
      idle(2);
      d_ready = 0;
      rsp_src.delete();
      srcs[0] = 9'h011; srcs[1] = 9'h022; srcs[2] = 9'h133;
      sent = 0;
      budget = 0;
      while (sent < 3 && budget < 30) begin
         a_valid = 1; a_opcode = 3'd4; a_address = '0; a_address[11:3] = 9'(sent);
         a_source = srcs[sent]; a_size = 2'(sent); a_mask = 8'hFF;
         if (budget == 4) d_ready = 1;
         step();
         if (last_acc) sent++;
         budget++;
      end
      a_valid = 0;
      chk("q_sent", 64'(sent), 64'd3);
      idle(3);
      chk("q_nrsp", 64'(rsp_src.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < rsp_src.size()) chk("q_src_order", 64'(rsp_src[k]), 64'(srcs[k]));
      end

      // 6: async reset mid-pulse with a response pending
      put(1, 64'h2, 8'h01);
      step();
      d_ready = 0;
      req(3'd4, 0, 64'h0, 8'hFF);
      step();
      reset = 0;
      #1;
      chk("arst_out", 64'(tile_reset_o), 64'(RINIT));
      chk("arst_dvalid", 64'(d_valid), 64'h0);
      model_reset();
      idle(3);
      reset = 1;
      d_ready = 1;
      n0 = n_rsp;
      idle(3);
      chk("no_stale_rsp", 64'(n_rsp - n0), 64'h0);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         int idx, sel;
         logic [63:0] data;
         logic [ADDR_W-1:0] addr;
         idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 511)) : int'($urandom_range(0, 3));
         addr       = ADDR_W'($urandom);
         addr[11:3] = 9'(idx);
         data = {$urandom, $urandom};
         if (idx == 2) data[7:0] = 8'($urandom_range(0, 6));
         sel = $urandom_range(0, 3);
         a_valid   = ($urandom_range(0, 2) != 0);
         a_opcode  = (sel == 0) ? 3'd4 : (sel == 1) ? 3'd0 : (sel == 2) ? 3'd1 : 3'($urandom);
         a_address = addr;
         a_data    = data;
         a_mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
         a_size    = 2'($urandom);
         a_source  = SRC_W'($urandom);
         d_ready   = ($urandom_range(0, 3) != 0);
         step();
      end
      a_valid = 0;
      d_ready = 1;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
